// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master word-bus arbiter.
package bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } t_arb_state;

   typedef logic [1:0] t_owner;

   localparam t_owner OWNER_NONE = 2'b00;
   localparam t_owner OWNER_M0   = 2'b01;
   localparam t_owner OWNER_M1   = 2'b10;

   // Debug owner code for an arbiter state.
   function automatic t_owner owner_of(input t_arb_state s);
      case (s)
         OWN0:    return OWNER_M0;
         OWN1:    return OWNER_M1;
         default: return OWNER_NONE;
      endcase
   endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one word bus between the core (M0) and a DMA/video master (M1),
// with per-master lock, bounded tenure and owner-only handshake return.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_lock,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m0_data_out,
   input  logic [DATA_W-1:0] m1_data_out,
   input  logic [STRB_W-1:0] m0_data_strobes,
   input  logic [STRB_W-1:0] m1_data_strobes,
   input  logic              m0_read,
   input  logic              m1_read,
   input  logic              m0_write,
   input  logic              m1_write,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic              m0_bus_error,
   output logic              m1_bus_error,
   output logic [DATA_W-1:0] m0_data_in,
   output logic [DATA_W-1:0] m1_data_in,
   output logic [ADDR_W-1:0] bus_address,
   output logic [DATA_W-1:0] bus_data_out,
   output logic [STRB_W-1:0] bus_data_strobes,
   output logic              bus_read,
   output logic              bus_write,
   input  logic [DATA_W-1:0] bus_data_in,
   input  logic              bus_ready,
   input  logic              bus_error,
   output logic [1:0]        owner
);

   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   t_arb_state        state;
   t_arb_state        state_nxt;
   t_arb_state        other_state;
   t_owner            last_owner;
   logic [HOLD_W-1:0] hold_cnt;

   logic own_req;
   logic oth_req;
   logic own_lock;
   logic own_busy;
   logic xfer_done;
   logic pending;
   logic handover;
   logic hold_inc;

   // Present owner's view of the request/lock/cycle inputs.
   always_comb begin
      own_req     = 1'b0;
      oth_req     = 1'b0;
      own_lock    = 1'b0;
      own_busy    = 1'b0;
      other_state = IDLE;
      case (state)
         OWN0: begin
            own_req     = m0_req;
            oth_req     = m1_req;
            own_lock    = m0_lock;
            own_busy    = m0_read | m0_write;
            other_state = OWN1;
         end
         OWN1: begin
            own_req     = m1_req;
            oth_req     = m0_req;
            own_lock    = m1_lock;
            own_busy    = m1_read | m1_write;
            other_state = OWN0;
         end
         default: ;
      endcase
   end

   assign xfer_done = own_busy & bus_ready;
   assign pending   = own_busy & ~bus_ready;
   // Locked owners yield only once their tenure reaches MAX_HOLD completed transfers.
   assign handover  = xfer_done & oth_req & (~own_lock | (hold_cnt >= HOLD_LAST));
   assign hold_inc  = xfer_done & oth_req & (hold_cnt < HOLD_MAX);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_nxt = (last_owner == OWNER_M0) ? OWN1 : OWN0;
            end else if (m0_req) begin
               state_nxt = OWN0;
            end else if (m1_req) begin
               state_nxt = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (pending) begin
               state_nxt = state;
            end else if (!own_req) begin
               state_nxt = oth_req ? other_state : IDLE;
            end else if (handover) begin
               state_nxt = other_state;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_owner <= OWNER_M1;
         hold_cnt   <= '0;
         m0_grant   <= 1'b0;
         m1_grant   <= 1'b0;
         owner      <= OWNER_NONE;
      end else begin
         state    <= state_nxt;
         m0_grant <= (state_nxt == OWN0);
         m1_grant <= (state_nxt == OWN1);
         owner    <= owner_of(state_nxt);
         if ((state_nxt != state) && (state_nxt != IDLE)) begin
            hold_cnt   <= '0;
            last_owner <= owner_of(state_nxt);
         end else if (hold_inc) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   // Bus and handshake mux: only the owner drives the fabric and sees completions.
   always_comb begin
      bus_address      = '0;
      bus_data_out     = '0;
      bus_data_strobes = '0;
      bus_read         = 1'b0;
      bus_write        = 1'b0;
      m0_ack           = 1'b0;
      m1_ack           = 1'b0;
      m0_bus_error     = 1'b0;
      m1_bus_error     = 1'b0;
      m0_data_in       = '0;
      m1_data_in       = '0;
      case (state)
         OWN0: begin
            bus_address      = m0_address;
            bus_data_out     = m0_data_out;
            bus_data_strobes = m0_data_strobes;
            bus_read         = m0_read;
            bus_write        = m0_write;
            m0_ack           = xfer_done;
            m0_bus_error     = xfer_done & bus_error;
            m0_data_in       = xfer_done ? bus_data_in : '0;
         end
         OWN1: begin
            bus_address      = m1_address;
            bus_data_out     = m1_data_out;
            bus_data_strobes = m1_data_strobes;
            bus_read         = m1_read;
            bus_write        = m1_write;
            m1_ack           = xfer_done;
            m1_bus_error     = xfer_done & bus_error;
            m1_data_in       = xfer_done ? bus_data_in : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a cycle-level ownership model.
module tb_bus_arbiter;

   localparam int unsigned MAXH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req, lock, rd, wr;
   logic [29:0] addr [2];
   logic [31:0] dout [2];
   logic [3:0]  strb [2];
   logic [31:0] bdin;
   logic        brdy, berr;

   logic        g0, g1, ack0, ack1, err0, err1, brd, bwr;
   logic [31:0] din0, din1, bdout;
   logic [29:0] baddr;
   logic [3:0]  bstrb;
   logic [1:0]  owner;

   int checks   = 0;
   int failures = 0;

   // Model: owner 0 = none, 1 = M0, 2 = M1.
   int m_own, m_last, m_hold;

   bus_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clock(clock), .reset(reset),
      .m0_req(req[0]), .m1_req(req[1]), .m0_lock(lock[0]), .m1_lock(lock[1]),
      .m0_address(addr[0]), .m1_address(addr[1]),
      .m0_data_out(dout[0]), .m1_data_out(dout[1]),
      .m0_data_strobes(strb[0]), .m1_data_strobes(strb[1]),
      .m0_read(rd[0]), .m1_read(rd[1]), .m0_write(wr[0]), .m1_write(wr[1]),
      .m0_grant(g0), .m1_grant(g1), .m0_ack(ack0), .m1_ack(ack1),
      .m0_bus_error(err0), .m1_bus_error(err1),
      .m0_data_in(din0), .m1_data_in(din1),
      .bus_address(baddr), .bus_data_out(bdout), .bus_data_strobes(bstrb),
      .bus_read(brd), .bus_write(bwr),
      .bus_data_in(bdin), .bus_ready(brdy), .bus_error(berr),
      .owner(owner)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_own  = 0;
      m_last = 2;
      m_hold = 0;
   endtask

   // Expected outputs for the current inputs and modelled owner.
   task automatic check_outputs();
      int          x;
      logic [1:0]  e_ack, e_err, e_own;
      logic [31:0] e_din0, e_din1, e_dout;
      logic [29:0] e_addr;
      logic [3:0]  e_strb;
      logic        e_rd, e_wr;
      e_ack = '0; e_err = '0; e_din0 = '0; e_din1 = '0;
      e_dout = '0; e_addr = '0; e_strb = '0; e_rd = 1'b0; e_wr = 1'b0;
      e_own = 2'(m_own);
      if (m_own != 0) begin
         x      = m_own - 1;
         e_addr = addr[x];
         e_dout = dout[x];
         e_strb = strb[x];
         e_rd   = rd[x];
         e_wr   = wr[x];
         if ((rd[x] | wr[x]) && brdy) begin
            e_ack[x] = 1'b1;
            e_err[x] = berr;
            if (x == 0) e_din0 = bdin;
            else        e_din1 = bdin;
         end
      end
      chk("grant0", 64'(g0), 64'(m_own == 1));
      chk("grant1", 64'(g1), 64'(m_own == 2));
      chk("owner", 64'(owner), 64'(e_own));
      chk("bus_address", 64'(baddr), 64'(e_addr));
      chk("bus_data_out", 64'(bdout), 64'(e_dout));
      chk("bus_strobes", 64'(bstrb), 64'(e_strb));
      chk("bus_read", 64'(brd), 64'(e_rd));
      chk("bus_write", 64'(bwr), 64'(e_wr));
      chk("ack0", 64'(ack0), 64'(e_ack[0]));
      chk("ack1", 64'(ack1), 64'(e_ack[1]));
      chk("err0", 64'(err0), 64'(e_err[0]));
      chk("err1", 64'(err1), 64'(e_err[1]));
      chk("data_in0", 64'(din0), 64'(e_din0));
      chk("data_in1", 64'(din1), 64'(e_din1));
   endtask

   // Ownership rules applied at the clock edge.
   task automatic model_step();
      int  x, y, nxt;
      logic busy, done;
      nxt = m_own;
      if (m_own == 0) begin
         if (req[0] && req[1]) nxt = (m_last == 1) ? 2 : 1;
         else if (req[0])      nxt = 1;
         else if (req[1])      nxt = 2;
      end else begin
         x    = m_own - 1;
         y    = 1 - x;
         busy = rd[x] | wr[x];
         done = busy & brdy;
         if (done && req[y] && m_hold < int'(MAXH)) m_hold++;
         if (busy && !brdy)  nxt = m_own;
         else if (!req[x])   nxt = req[y] ? y + 1 : 0;
         else if (done && req[y] && (!lock[x] || m_hold >= int'(MAXH))) nxt = y + 1;
      end
      if (nxt != m_own && nxt != 0) begin
         m_last = nxt;
         m_hold = 0;
      end
      m_own = nxt;
   endtask

   task automatic settle();
      #1;
      check_outputs();
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic clear_inputs();
      req = '0; lock = '0; rd = '0; wr = '0;
      brdy = 1'b0; berr = 1'b0; bdin = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; dout[i] = '0; strb[i] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      #1;
      chk("rst_grant0", 64'(g0), 64'(0));
      chk("rst_grant1", 64'(g1), 64'(0));
      chk("rst_owner", 64'(owner), 64'(0));
      chk("rst_bus_read", 64'(brd), 64'(0));
      chk("rst_bus_write", 64'(bwr), 64'(0));
      chk("rst_ack0", 64'(ack0), 64'(0));
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      int          n_ack;
      int          guard;
      logic [1:0]  seq [5];
      reset = 1'b0;
      clear_inputs();

      // 1: single M0 read with delayed ready.
      do_reset();
      req[0] = 1'b1; rd[0] = 1'b1; addr[0] = 30'h100;
      settle();
      chk("t1_grant_early", 64'(g0), 64'(0));
      tick();
      settle();
      chk("t1_grant", 64'(g0), 64'(1));
      chk("t1_addr", 64'(baddr), 64'(30'h100));
      chk("t1_read", 64'(brd), 64'(1));
      tick();
      brdy = 1'b1; bdin = 32'hDEADBEEF;
      settle();
      chk("t1_ack0", 64'(ack0), 64'(1));
      chk("t1_data", 64'(din0), 64'(32'hDEADBEEF));
      chk("t1_ack1", 64'(ack1), 64'(0));
      tick();
      req[0] = 1'b0; rd[0] = 1'b0; brdy = 1'b0;
      step();
      settle();
      chk("t1_idle", 64'(owner), 64'(0));

      // 2: both requesting, no lock: M0 first, then strict alternation.
      do_reset();
      seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b01; seq[4] = 2'b10;
      req = 2'b11; rd = 2'b11; brdy = 1'b1; bdin = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk($sformatf("t2_owner%0d", i), 64'(owner), 64'(seq[i]));
         tick();
      end

      // 3: locked M0 is preempted after MAX_HOLD completed transfers.
      do_reset();
      req = 2'b11; lock = 2'b01; rd = 2'b11; brdy = 1'b1;
      step();
      n_ack = 0; guard = 0;
      settle();
      while (g0 === 1'b1 && guard < 20) begin
         if (ack0 === 1'b1) n_ack++;
         tick();
         settle();
         guard++;
      end
      chk("t3_acks", 64'(n_ack), 64'(MAXH));
      chk("t3_grant1", 64'(g1), 64'(1));

      // 4: M1 write stalled by ready; dropping req cannot steal ownership.
      req = 2'b00; lock = 2'b00; rd = 2'b00; wr = 2'b10; brdy = 1'b0;
      addr[1] = 30'h2000; strb[1] = 4'b0011; dout[1] = 32'hA5A5_0F0F;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("t4_grant1", 64'(g1), 64'(1));
         chk("t4_write", 64'(bwr), 64'(1));
         chk("t4_strobes", 64'(bstrb), 64'(4'b0011));
         tick();
      end
      brdy = 1'b1;
      settle();
      chk("t4_ack1", 64'(ack1), 64'(1));
      tick();
      wr = 2'b00; brdy = 1'b0;
      settle();
      chk("t4_owner_idle", 64'(owner), 64'(0));
      chk("t4_grant1_low", 64'(g1), 64'(0));
      tick();

      // 5: error reported only to the owning master.
      req[0] = 1'b1; rd[0] = 1'b1; addr[0] = 30'h44;
      step();
      brdy = 1'b1; berr = 1'b1; bdin = 32'hCAFE_F00D;
      settle();
      chk("t5_err0", 64'(err0), 64'(1));
      chk("t5_ack0", 64'(ack0), 64'(1));
      chk("t5_err1", 64'(err1), 64'(0));
      tick();
      req = 2'b00; rd = 2'b00; brdy = 1'b0; berr = 1'b0;
      step();

      // 6: asynchronous reset during an M1 transfer.
      req[1] = 1'b1; wr[1] = 1'b1;
      step();
      settle();
      chk("t6_grant1", 64'(g1), 64'(1));
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_grant0", 64'(g0), 64'(0));
      chk("t6_rst_grant1", 64'(g1), 64'(0));
      chk("t6_rst_read", 64'(brd), 64'(0));
      chk("t6_rst_write", 64'(bwr), 64'(0));
      chk("t6_rst_owner", 64'(owner), 64'(0));
      chk("t6_rst_ack1", 64'(ack1), 64'(0));
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      req = 2'b11; wr = 2'b00;
      step();
      settle();
      chk("t6_first_grant0", 64'(g0), 64'(1));
      chk("t6_first_grant1", 64'(g1), 64'(0));
      tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 2; i++) begin
            req[i]  = ($urandom_range(0, 3) != 0);
            lock[i] = 1'($urandom);
            rd[i]   = 1'($urandom);
            wr[i]   = ($urandom_range(0, 3) == 0);
            addr[i] = 30'($urandom);
            dout[i] = $urandom;
            strb[i] = 4'($urandom);
         end
         brdy = 1'($urandom);
         berr = ($urandom_range(0, 3) == 0);
         bdin = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single external word bus (address[31:2], data, strobes, read, write) between two masters: M0 is the maxicore32 core and M1 is a DMA or video requester.
- Sits between those masters and the memory/peripheral fabric.
- Grants the bus with registered round-robin arbitration and supports a per-master lock for multi-transfer sequences.
- Bounds bus tenure and reports slave handshakes and bus errors back to the owning master only.

Parameters:
- MAX_HOLD, 8: maximum consecutive completed transfers one master may make while the other is requesting. Range 1..255.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  master requests the bus; held high until the master is done.
- m0_lock, m1_lock  in  1  master asks to keep ownership across transfers; sampled only while that master owns the bus.
- m0_address, m1_address  in  30  word address [31:2].
- m0_data_out, m1_data_out  in  32  write data.
- m0_data_strobes, m1_data_strobes  in  4  byte lanes.
- m0_read, m1_read, m0_write, m1_write  in  1  cycle type.
- m0_grant, m1_grant  out  1  master owns the bus (registered).
- m0_ack, m1_ack  out  1  transfer complete this cycle.
- m0_bus_error, m1_bus_error  out  1  error on the completing transfer.
- m0_data_in, m1_data_in  out  32  read data.
- bus_address  out  30  to fabric.
- bus_data_out  out  32  to fabric.
- bus_data_strobes  out  4  to fabric.
- bus_read, bus_write  out  1  to fabric.
- bus_data_in  in  32  from fabric.
- bus_ready  in  1  fabric completes the current transfer.
- bus_error  in  1  fabric flags an error; qualified by bus_ready.
- owner  out  2  debug: 00 idle, 01 M0, 10 M1.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; grants 0; hold counter 0; last_owner = M1, so M0 wins first.
  - All bus_* outputs 0; all ack/error outputs 0.
- States are IDLE, OWN0 and OWN1, encoded in a shared enum.
- IDLE:
  - If exactly one request is high, go to that master's OWN state next edge.
  - If both are high, the master that is not last_owner wins.
  - Grant latency from req rising to grant high is 1 cycle.
  - No bus cycle is driven in IDLE: bus_read = bus_write = 0.
- OWN*x*:
  - bus_* outputs are driven combinationally from master x, gated by grant.
  - The non-owner's request has no effect on the bus.
  - A transfer completes when (mx_read | mx_write) & bus_ready. In that cycle:
    - mx_ack = 1;
    - mx_bus_error = bus_error;
    - mx_data_in = bus_data_in.
  - The non-owner sees ack 0, error 0 and data_in 0.
- Hold counter:
  - Increments on each completed transfer while the other master is requesting.
  - Clears on entry to any OWN state.
  - Saturates at MAX_HOLD.
- Leaving OWN*x* (evaluated at the edge):
  - If mx_req is low and no transfer is pending, go to IDLE, or directly to OWN*y* if my_req is high (handover with no idle cycle; the grant swaps in one edge).
  - On a completing transfer with mx_lock low and my_req high, go to OWN*y*.
  - On a completing transfer with mx_lock high, stay, unless the hold counter reaches MAX_HOLD with my_req high; then go to OWN*y* (forced preemption).
  - With mx_lock low and my_req low, stay while mx_req is high.
- Pending-cycle rule: ownership never changes while mx_read or mx_write is high without bus_ready. A master dropping req mid-cycle is a protocol violation; the arbiter keeps ownership until bus_ready.
- last_owner updates on every entry to OWN*x*.
- A master must hold its address and data stable from request until ack. The arbiter does not latch them.
- Simultaneous read and write from a master is forwarded unchanged; the businterface layer flags it.
- Reset asserted mid-transfer: outputs drop immediately and the transfer is abandoned, with no ack.

Decomposition:
- Shared package:
  - t_arb_state enum (IDLE, OWN0, OWN1);
  - t_owner 2-bit constants OWNER_NONE, OWNER_M0, OWNER_M1.
  - Placed alongside businterface.vh in an arbiter.vh include.
- No sub-module needed. The output mux is an always_comb block inside bus_arbiter.
- The hold counter is inline, 8 bits wide.

Test Plan:
1. Reset release, m0_req=1 with read at address 0x100, bus_ready=1 two cycles later:
   - m0_grant goes high 1 cycle after the request;
   - bus_address=0x100, bus_read=1;
   - m0_ack for 1 cycle with m0_data_in = bus_data_in = 0xDEADBEEF;
   - m1_ack stays 0.
2. Both requesting from IDLE after reset, no lock, bus_ready always 1:
   - M0 is granted first;
   - after its first completed transfer, ownership alternates M1, M0, M1.
3. m0_lock=1 with continuous transfers, m1_req=1, MAX_HOLD=4:
   - M0 completes exactly 4 transfers;
   - the grant moves to M1 on the edge after the 4th ack.
4. M1 owns, write to 0x2000 with strobes 0011, bus_ready held low for 5 cycles while m1_req drops:
   - m1_grant stays high until bus_ready;
   - then the bus goes IDLE and owner=00.
5. M0 read, bus_ready=1 and bus_error=1:
   - m0_bus_error=1 for one cycle together with m0_ack;
   - m1_bus_error=0.
6. Reset pulsed low during an M1 transfer:
   - all grants, bus_read, bus_write and owner go to 0 asynchronously;
   - after release, the first contended grant goes to M0.
